nibble_link_rx: RTL and testbench

- Receive end of the inverting nibble pin link between tiles.
- The transmitting tile drives a data nibble through inverter cells, so pins carry active-low data, plus a toggle strobe and a start-of-frame flag.
- This block synchronises the pins, detects strobe toggles, re-inverts and assembles two nibbles (low first) into a byte.
- It flags framing and timeout errors and keeps a saturating error count.

---
 rtl/nibble_link_rx.sv | 177 +++++++++++++++++
 tb/tb_nibble_link_rx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_link_rx.sv
// ---------------------------------------------------------------------------
// nibble_link_rx
//
// Receive end of the inverting nibble pin link between tiles. The far tile
// drives its data nibble through inverter cells, so the pins carry active-low
// data. A toggle strobe marks each new nibble, and a start-of-frame flag
// accompanies the first (low) nibble of each byte.
//
// Every pin is brought into the clk domain through a SYNC_STAGES-deep flop
// chain. Strobe level changes are detected and registered together with the
// re-inverted nibble and the sof flag. A two-state FSM then pairs nibbles
// (low first) into bytes. It flags framing and timeout errors and keeps a
// saturating error count.
//
// Parameters
//   SYNC_STAGES  synchroniser depth (2..4)
//   TIMEOUT      cycles allowed in WAIT_HI without a strobe toggle (1..65535)
//   ERR_W        width of the saturating error counter
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous, active-high reset; clears all state
//   ena         in   when low, toggles are ignored and state/timer freeze
//   rx_nib_n    in   [3:0] inverted data nibble from the pins (async)
//   rx_stb      in   toggle strobe, one level change per nibble (async)
//   rx_sof      in   high with the low nibble of a byte (async)
//   byte_data   out  [7:0] last assembled byte {hi, lo}, true polarity
//   byte_valid  out  one-cycle pulse when byte_data updates
//   frame_err   out  one-cycle pulse on a framing or timeout error
//   err_count   out  [ERR_W-1:0] saturating count of frame_err pulses
//   busy        out  high while waiting for the high nibble
// ---------------------------------------------------------------------------
module nibble_link_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 255,
   parameter int ERR_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [3:0]       rx_nib_n,
   input  logic             rx_stb,
   input  logic             rx_sof,
   output logic [7:0]       byte_data,
   output logic             byte_valid,
   output logic             frame_err,
   output logic [ERR_W-1:0] err_count,
   output logic             busy
);

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   typedef enum logic {
      IDLE    = 1'b0,
      WAIT_HI = 1'b1
   } state_t;

   // Saturating increment: the count sticks at all-ones instead of wrapping.
   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] cnt);
      return (&cnt) ? cnt : cnt + ERR_W'(1);
   endfunction

   logic [3:0]             nib_sync [SYNC_STAGES];
   logic [SYNC_STAGES-1:0] stb_sync;
   logic [SYNC_STAGES-1:0] sof_sync;
   logic                   stb_prev;

   logic                   vld_p0;
   logic [3:0]             nib_p0;
   logic                   sof_p0;

   state_t                 state;
   logic [15:0]            timer;
   logic [3:0]             lo_reg;

   // ---- synchroniser: pins -> clk domain --------------------------------
   // The nibble idles at 4'hF on the pins (true value 0).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            nib_sync[i] <= 4'hF;
         end
         stb_sync <= '0;
         sof_sync <= '0;
      end else begin
         nib_sync[0] <= rx_nib_n;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            nib_sync[i] <= nib_sync[i-1];
         end
         stb_sync <= {stb_sync[SYNC_STAGES-2:0], rx_stb};
         sof_sync <= {sof_sync[SYNC_STAGES-2:0], rx_sof};
      end
   end

   // ---- stage p0: strobe edge detect, nibble re-inversion ---------------
   // stb_prev follows the synced strobe even while ena is low. Re-enabling
   // therefore never sees a stale level difference as a new nibble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stb_prev <= 1'b0;
         vld_p0   <= 1'b0;
         nib_p0   <= 4'h0;
         sof_p0   <= 1'b0;
      end else begin
         stb_prev <= stb_sync[SYNC_STAGES-1];
         vld_p0   <= stb_sync[SYNC_STAGES-1] ^ stb_prev;
         nib_p0   <= ~nib_sync[SYNC_STAGES-1];
         sof_p0   <= sof_sync[SYNC_STAGES-1];
      end
   end

   // ---- stage p1: frame FSM and registered outputs ----------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         timer      <= 16'h0000;
         lo_reg     <= 4'h0;
         byte_data  <= 8'h00;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         err_count  <= '0;
         busy       <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (ena) begin
            case (state)
               IDLE: begin
                  if (vld_p0) begin
                     if (sof_p0) begin
                        lo_reg <= nib_p0;
                        timer  <= 16'h0000;
                        state  <= WAIT_HI;
                        busy   <= 1'b1;
                     end else begin
                        // High nibble with no low nibble before it.
                        frame_err <= 1'b1;
                        err_count <= sat_inc(err_count);
                     end
                  end
               end
               WAIT_HI: begin
                  // A toggle takes priority over a timeout in the same cycle.
                  if (vld_p0) begin
                     if (!sof_p0) begin
                        byte_data  <= {nib_p0, lo_reg};
                        byte_valid <= 1'b1;
                        timer      <= 16'h0000;
                        state      <= IDLE;
                        busy       <= 1'b0;
                     end else begin
                        // A new sof: drop the old low nibble and restart.
                        frame_err <= 1'b1;
                        err_count <= sat_inc(err_count);
                        lo_reg    <= nib_p0;
                        timer     <= 16'h0000;
                     end
                  end else if (timer == TMO_LAST) begin
                     frame_err <= 1'b1;
                     err_count <= sat_inc(err_count);
                     timer     <= 16'h0000;
                     state     <= IDLE;
                     busy      <= 1'b0;
                  end else begin
                     timer <= timer + 16'd1;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_nibble_link_rx.sv
// ---------------------------------------------------------------------------
// tb_nibble_link_rx
//
// Drives two receivers from the same pins. Receiver d1 uses the default
// synchroniser depth and an 8-bit counter. Receiver d2 uses a 3-stage
// synchroniser and a 2-bit counter, so its error count saturates at 3.
// Directed frames come first, followed by a randomized run of nibbles.
// The randomized run is scored against a frame-level model. That model
// tracks only the frame state, the pending low nibble, the gap between
// toggles and the byte list.
// ---------------------------------------------------------------------------
module tb_nibble_link_rx;

   localparam int S  = 2;
   localparam int T  = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [3:0] nib_n;
   logic       stb;
   logic       sof;

   logic [7:0] d1_data, d2_data;
   logic       d1_valid, d2_valid, d1_ferr, d2_ferr, d1_busy, d2_busy;
   logic [7:0] d1_err;
   logic [1:0] d2_err;

   int checks   = 0;
   int failures = 0;

   int v1 = 0, v2 = 0, f1 = 0, f2 = 0, busy_cyc = 0;
   logic [7:0] q1 [$];
   logic [7:0] q2 [$];

   always #5 clk = ~clk;

   nibble_link_rx #(.SYNC_STAGES(S), .TIMEOUT(T), .ERR_W(8)) d1 (
      .clk(clk), .rst(rst), .ena(ena), .rx_nib_n(nib_n), .rx_stb(stb),
      .rx_sof(sof), .byte_data(d1_data), .byte_valid(d1_valid),
      .frame_err(d1_ferr), .err_count(d1_err), .busy(d1_busy)
   );

   nibble_link_rx #(.SYNC_STAGES(3), .TIMEOUT(T), .ERR_W(2)) d2 (
      .clk(clk), .rst(rst), .ena(ena), .rx_nib_n(nib_n), .rx_stb(stb),
      .rx_sof(sof), .byte_data(d2_data), .byte_valid(d2_valid),
      .frame_err(d2_ferr), .err_count(d2_err), .busy(d2_busy)
   );

   // Pulse and byte monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (d1_valid) begin
         q1.push_back(d1_data);
         v1++;
      end
      if (d2_valid) begin
         q2.push_back(d2_data);
         v2++;
      end
      if (d1_ferr) f1++;
      if (d2_ferr) f2++;
      if (d1_busy) busy_cyc++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Put the true nibble on the pins inverted, hold it one cycle, then toggle
   // the strobe. The next toggle comes 'gap' cycles after this one.
   task automatic send_nib(input logic [3:0] val, input logic s, input int gap);
      nib_n = ~val;
      sof   = s;
      cyc(1);
      stb = ~stb;
      cyc(gap - 1);
   endtask

   int          b_v1, b_f1, b_bc, b_v2, b_f2, lat;
   bit          found;
   logic [7:0]  exp_q [$];
   bit          m_wait;
   logic [3:0]  m_lo;
   int          m_err, m_gap, gap, n_cmp;
   logic [3:0]  r_nib;
   logic        r_sof;

   initial begin
      rst = 1'b1; ena = 1'b1; nib_n = 4'hF; stb = 1'b0; sof = 1'b0;
      cyc(3);
      check_val("rst_byte_data", 32'(d1_data), 32'h00);
      check_val("rst_byte_valid", 32'(d1_valid), 32'h0);
      check_val("rst_frame_err", 32'(d1_ferr), 32'h0);
      check_val("rst_err_count", 32'(d1_err), 32'h0);
      check_val("rst_busy", 32'(d1_busy), 32'h0);
      rst = 1'b0;
      cyc(3);

      // Byte 0xA5 (pins 0xA then 0x5), with the latency measured.
      b_v1 = v1; b_f1 = f1;
      send_nib(4'h5, 1'b1, 4);
      nib_n = ~4'hA; sof = 1'b0;
      cyc(1);
      stb = ~stb;
      lat = 0; found = 0;
      for (int k = 1; k <= S + 6; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (d1_valid && !found) begin
            lat = k;
            found = 1;
         end
      end
      check_val("a5_latency", 32'(lat), 32'(S + 2));
      check_val("a5_data", 32'(d1_data), 32'hA5);
      check_val("a5_valid_pulses", 32'(v1 - b_v1), 32'd1);
      check_val("a5_no_ferr", 32'(f1 - b_f1), 32'd0);
      cyc(2);

      // High nibble with no sof while IDLE.
      b_v1 = v1; b_f1 = f1; b_bc = busy_cyc;
      send_nib(4'h6, 1'b0, 4);
      cyc(S + 4);
      check_val("idle_hi_ferr", 32'(f1 - b_f1), 32'd1);
      check_val("idle_hi_errcnt", 32'(d1_err), 32'd1);
      check_val("idle_hi_no_valid", 32'(v1 - b_v1), 32'd0);
      check_val("idle_hi_busy_low", 32'(busy_cyc - b_bc), 32'd0);

      // Timeout after low nibble 0x3, then a good frame 0x73.
      b_v1 = v1; b_f1 = f1; b_bc = busy_cyc;
      send_nib(4'h3, 1'b1, 2);
      cyc(T + S + 6);
      check_val("tmo_ferr", 32'(f1 - b_f1), 32'd1);
      check_val("tmo_busy_cycles", 32'(busy_cyc - b_bc), 32'(T));
      check_val("tmo_busy_low", 32'(d1_busy), 32'd0);
      check_val("tmo_no_valid", 32'(v1 - b_v1), 32'd0);
      send_nib(4'h3, 1'b1, 4);
      send_nib(4'h7, 1'b0, 4);
      cyc(S + 4);
      check_val("after_tmo_data", 32'(d1_data), 32'h73);
      check_val("after_tmo_valid", 32'(v1 - b_v1), 32'd1);

      // A second sof restarts the frame.
      b_v1 = v1; b_f1 = f1;
      send_nib(4'h1, 1'b1, 4);
      send_nib(4'h2, 1'b1, 4);
      send_nib(4'hF, 1'b0, 4);
      cyc(S + 4);
      check_val("resof_ferr", 32'(f1 - b_f1), 32'd1);
      check_val("resof_data", 32'(d1_data), 32'hF2);
      check_val("resof_valid", 32'(v1 - b_v1), 32'd1);

      // Full frame while disabled, then re-enable with the strobe unchanged.
      b_v1 = v1; b_f1 = f1; b_bc = busy_cyc;
      ena = 1'b0;
      cyc(2);
      send_nib(4'h4, 1'b1, 4);
      send_nib(4'h9, 1'b0, 4);
      cyc(S + 6);
      ena = 1'b1;
      cyc(S + 6);
      check_val("ena_no_valid", 32'(v1 - b_v1), 32'd0);
      check_val("ena_no_ferr", 32'(f1 - b_f1), 32'd0);
      check_val("ena_no_busy", 32'(busy_cyc - b_bc), 32'd0);
      check_val("ena_data_held", 32'(d1_data), 32'hF2);
      send_nib(4'h6, 1'b1, 4);
      send_nib(4'hC, 1'b0, 4);
      cyc(S + 5);
      check_val("reena_data", 32'(d1_data), 32'hC6);
      check_val("reena_valid", 32'(v1 - b_v1), 32'd1);

      // Saturation: 3 errors so far, force 2 more.
      check_val("sat_pre_d1", 32'(d1_err), 32'd3);
      check_val("sat_pre_d2", 32'(d2_err), 32'd3);
      send_nib(4'h0, 1'b0, 4);
      send_nib(4'h0, 1'b0, 4);
      cyc(S + 5);
      check_val("sat_d1_count", 32'(d1_err), 32'd5);
      check_val("sat_d2_stuck", 32'(d2_err), 32'd3);

      // Reset while waiting for the high nibble.
      send_nib(4'h8, 1'b1, 2);
      cyc(S + 2);
      check_val("rst_mid_busy", 32'(d1_busy), 32'd1);
      rst = 1'b1; stb = 1'b0; nib_n = 4'hF; sof = 1'b0;
      cyc(2);
      check_val("rst_mid_data", 32'(d1_data), 32'h00);
      check_val("rst_mid_err", 32'(d1_err), 32'h0);
      check_val("rst_mid_busy_low", 32'(d1_busy), 32'h0);
      rst = 1'b0;
      cyc(3);
      b_v1 = v1; b_v2 = v2;
      send_nib(4'hB, 1'b0, 4);
      cyc(S + 5);
      check_val("rst_lost_no_valid", 32'(v1 - b_v1), 32'd0);
      check_val("rst_lost_data", 32'(d1_data), 32'h00);
      check_val("rst_lost_err_d1", 32'(d1_err), 32'd1);
      check_val("rst_lost_err_d2", 32'(d2_err), 32'd1);

      // Randomized run against the frame-level model.
      q1.delete(); q2.delete(); exp_q.delete();
      b_f1 = f1; b_f2 = f2;
      m_wait = 0; m_lo = 4'h0; m_err = 0; m_gap = 0;
      for (int i = 0; i < 150; i++) begin
         r_nib = 4'($urandom_range(0, 15));
         r_sof = ($urandom_range(0, 9) < 6);
         case ($urandom_range(0, 9))
            0:       gap = T;
            1:       gap = T + 1;
            default: gap = $urandom_range(2, 8);
         endcase
         // Timeout fires if the previous toggle left us waiting too long.
         if (i > 0 && m_wait && m_gap > T) begin
            m_err++;
            m_wait = 0;
         end
         if (!m_wait) begin
            if (r_sof) begin
               m_lo = r_nib;
               m_wait = 1;
            end else begin
               m_err++;
            end
         end else if (r_sof) begin
            m_err++;
            m_lo = r_nib;
         end else begin
            exp_q.push_back({r_nib, m_lo});
            m_wait = 0;
         end
         m_gap = gap;
         send_nib(r_nib, r_sof, gap);
      end
      cyc(T + S + 8);
      if (m_wait) m_err++;

      check_val("rnd_byte_count_d1", 32'(q1.size()), 32'(exp_q.size()));
      check_val("rnd_byte_count_d2", 32'(q2.size()), 32'(exp_q.size()));
      n_cmp = (q1.size() < exp_q.size()) ? q1.size() : exp_q.size();
      for (int i = 0; i < n_cmp; i++) begin
         check_val($sformatf("rnd_byte_d1[%0d]", i), 32'(q1[i]), 32'(exp_q[i]));
      end
      n_cmp = (q2.size() < exp_q.size()) ? q2.size() : exp_q.size();
      for (int i = 0; i < n_cmp; i++) begin
         check_val($sformatf("rnd_byte_d2[%0d]", i), 32'(q2[i]), 32'(exp_q[i]));
      end
      check_val("rnd_ferr_d1", 32'(f1 - b_f1), 32'(m_err));
      check_val("rnd_ferr_d2", 32'(f2 - b_f2), 32'(m_err));
      check_val("rnd_errcnt_d1", 32'(d1_err), 32'((1 + m_err > 255) ? 255 : 1 + m_err));
      check_val("rnd_errcnt_d2", 32'(d2_err), 32'((1 + m_err > 3) ? 3 : 1 + m_err));
      check_val("rnd_idle_end", 32'(d1_busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
